cpu_phase_ctrl: RTL

- Multicycle sequencer for the MIPS core.
- Generates the one-hot fetch/exec1/exec2 phase strobes consumed by the PC, decoder and register file.
- Owns the single Avalon-style memory port: instruction read in FETCH, optional data read/write in EXEC1.
- Latches the instruction word, freezes phase progress on waitrequest, and parks the core when the PC reports halt.

---
 rtl/cpu_pkg.sv | 6 +
 rtl/cpu_phase_ctrl.sv | 78 +++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared phase-sequencer types and constants for the MIPS core
package cpu_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, EXEC1, EXEC2, HALTED} phase_state_t;
    localparam logic [3:0] BYTE_EN_ALL = 4'hF;
    localparam logic [31:0] HALT_ADDR = 32'h0;
endpackage

// File: rtl/cpu_phase_ctrl.sv
// cpu_phase_ctrl: multicycle fetch/exec1/exec2 sequencer owning the single memory port
module cpu_phase_ctrl
    import cpu_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 0,
    parameter int TO_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_address,
    input  logic        pc_halt,
    input  logic        data_read_req,
    input  logic        data_write_req,
    input  logic [31:0] data_address,
    input  logic [31:0] data_writedata,
    input  logic [3:0]  data_byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        fetch,
    output logic        exec1,
    output logic        exec2,
    output logic        stall,
    output logic        active,
    output logic        bus_error,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    output logic [31:0] instr,
    output logic [31:0] data_readdata
);
    phase_state_t state, nxt;
    logic [TO_W-1:0] wd_cnt;
    logic acc, timeout;
    always_comb begin
        acc = state == EXEC1 && (data_write_req || data_read_req);
        stall = !reset && (state == FETCH || acc) && waitrequest;
        timeout = WAIT_TIMEOUT != 0 && stall && ({1'b0, wd_cnt} + 1'b1) >= (TO_W+1)'(WAIT_TIMEOUT);
        write = !reset && acc && data_write_req;
        read = !reset && (state == FETCH || (acc && !data_write_req));
        address = acc ? data_address : pc_address;
        byteenable = acc ? data_byteenable : BYTE_EN_ALL;
        writedata = data_writedata;
        unique case (state)
            IDLE:    nxt = FETCH;
            FETCH:   nxt = waitrequest ? FETCH : EXEC1;
            EXEC1:   nxt = acc && waitrequest ? EXEC1 : EXEC2;
            EXEC2:   nxt = pc_halt ? HALTED : FETCH;
            default: nxt = HALTED;
        endcase
        if (timeout) nxt = HALTED;
    end
    // phase strobes are registered from the next state so they line up with state
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            fetch <= 1'b0;
            exec1 <= 1'b0;
            exec2 <= 1'b0;
            active <= 1'b0;
            bus_error <= 1'b0;
            instr <= '0;
            data_readdata <= '0;
            wd_cnt <= '0;
        end else begin
            state <= nxt;
            fetch <= nxt == FETCH;
            exec1 <= nxt == EXEC1;
            exec2 <= nxt == EXEC2;
            active <= nxt == FETCH || nxt == EXEC1 || nxt == EXEC2;
            wd_cnt <= stall ? wd_cnt + 1'b1 : '0;
            if (timeout) bus_error <= 1'b1;
            if (state == FETCH && !waitrequest) instr <= readdata;
            if (acc && !data_write_req && !waitrequest) data_readdata <= readdata;
        end
    end
endmodule
